fsm_datapath: RTL and testbench
===============================

FSM_DATAPATH -- requirements
Module: fsm_datapath

Interface
REQ-001 Parameter XLEN, default 64: datapath and register width in bits; legal values 32 or 64.
REQ-002 Parameter NREG, default 32: number of architectural registers.
REQ-003 Parameter IMEM_DEPTH, default 64: instruction memory depth in 32-bit words.
REQ-004 Parameter DMEM_DEPTH, default 64: data memory depth in XLEN-bit words.
REQ-005 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-006 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 Port imem_we, input, 1 bit: instruction memory write strobe; the bench loads the program while rst is high.
REQ-009 Port imem_addr, input, log2(IMEM_DEPTH) bits: word index for an instruction memory write.
REQ-010 Port imem_wdata, input, 32 bits: instruction word to write.
REQ-011 Port PC, output, XLEN bits: address of the instruction currently in flight.
REQ-012 Port New_PC, output, XLEN bits: next PC, valid when retire is high.
REQ-013 Port ans, output, XLEN bits: ALU result (sum, difference or address) of the latest executed instruction.
REQ-014 Port I, output, 32 bits: instruction word currently latched.
REQ-015 Port retire, output, 1 bit: pulses high for one cycle as each instruction completes.
REQ-016 Port trap, output, 1 bit: sticky illegal-instruction flag.

Function
REQ-017 The block SHALL be a multicycle machine with the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-018 The supported instructions SHALL be add, sub, addi, ld (lw when XLEN is 32), sd (sw when XLEN is 32) and beq, all in standard RV encodings.
REQ-019 State transitions SHALL be:
  - FETCH->DECODE->EXEC always.
  - From EXEC: R-type and addi go to WB; ld and sd go to MEM; beq returns to FETCH.
  - From MEM: ld goes to WB; sd returns to FETCH.
  - WB returns to FETCH.
REQ-020 Latencies in cycles, counted from entering FETCH to the retire pulse, SHALL be: beq 3, add/sub/addi 4, sd 4, ld 5.
REQ-021 retire SHALL assert in the final state of each instruction, and PC SHALL take the value of New_PC on the following edge.
REQ-022 New_PC SHALL equal PC + (sign-extended B-immediate) when beq is taken, and PC + 4 otherwise.
REQ-023 Branch offsets SHALL be measured in bytes.
REQ-024 Register x0 SHALL read as 0, and writes to x0 SHALL be discarded.
REQ-025 All arithmetic SHALL be modulo 2^XLEN and sign-agnostic; immediates SHALL be sign-extended to XLEN.
REQ-026 Instruction fetch SHALL use word index PC[log2(IMEM_DEPTH)+1:2]; the upper bits are ignored, so addresses wrap.
REQ-027 A data access SHALL use word index addr >> log2(XLEN/8), taken modulo DMEM_DEPTH; the low address bits are ignored, so misaligned accesses are truncated.
REQ-028 A load SHALL write the register file in WB, and a store SHALL write memory in MEM.
REQ-029 A register value read in DECODE SHALL reflect every write from prior instructions.
REQ-030 imem_we asserted while rst is low SHALL still write memory; the effect on an in-flight fetch of that same word is undefined.

Reset
REQ-031 On rst asserted, the block SHALL asynchronously force: state=FETCH, PC=RESET_PC, New_PC=RESET_PC, ans=0, I=0, retire=0, trap=0, and every register to 0.
REQ-032 Data memory and instruction memory SHALL NOT be cleared by reset.
REQ-033 Reset asserted mid-instruction SHALL abandon that instruction with no register or memory write.
REQ-034 Execution SHALL resume in FETCH on the first rising edge after rst deasserts.

Configuration
REQ-035 Macro ILLEGAL_TRAP_EN SHALL control handling of unsupported opcodes or funct fields.
REQ-036 With ILLEGAL_TRAP_EN defined, an illegal instruction in DECODE SHALL go to TRAP, set trap=1 and freeze PC with no retire; only rst exits TRAP.
REQ-037 Without ILLEGAL_TRAP_EN, an illegal instruction SHALL execute as a NOP in 3 cycles with New_PC=PC+4, and trap SHALL be tied to 0.

Structure
REQ-038 A shared package SHALL hold the opcode/funct3/funct7 constants, the state enumeration and the ALU-op enumeration.
REQ-039 The register file SHALL be a sub-module named regfile: 2 read ports, 1 write port, x0 hard-wired to zero, parameterised by XLEN and NREG.

Verification
REQ-040 Program ld x2,0(x9); ld x1,8(x9); beq x2,x1,+12; sub x3,x2,x1; sd x3,16(x9), with x9=0, mem[0]=30, mem[1]=10 -> mem[2]=20, and retire pulses on cycles 5,10,13,17,21.
REQ-041 Same program with mem[0]=mem[1]=10, branch target addi x3,x2,-20; sd x3,16(x9) -> branch taken, New_PC=PC+12, mem[2]=2^XLEN-10.
REQ-042 addi x0,x0,5 followed by add x1,x0,x0 -> x1=0 and ans=0.
REQ-043 rst pulsed during the MEM state of sd -> target word unchanged, PC=RESET_PC.
REQ-044 Instruction 0xFFFFFFFF -> with ILLEGAL_TRAP_EN: trap=1 and PC frozen for 10 cycles; without it: New_PC=PC+4 and trap=0.
REQ-045 XLEN=32 with lw/sw and addi x1,x0,-1 -> x1=32'hFFFFFFFF, and stores are word-indexed by addr>>2.

Source files
------------

// File: rtl/fsm_datapath_pkg.sv
// Shared definitions for the multicycle fsm_datapath core.
// Holds the RV opcode/funct constants, the FSM state and ALU-op
// enumerations, and a decoder that sorts an instruction word into the
// supported instruction classes.
package fsm_datapath_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_WORD    = 3'b010;  // lw / sw
    localparam logic [2:0] F3_DWORD   = 3'b011;  // ld / sd

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    typedef enum logic [0:0] {
        ALU_ADD, ALU_SUB
    } alu_op_e;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_ADDI, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILLEGAL
    } cls_e;

    typedef struct packed {
        cls_e    cls;
        alu_op_e alu_op;
    } dec_t;

    // f3_mem selects the load/store width code the core accepts
    // (word for a 32-bit datapath, doubleword for 64-bit).
    function automatic dec_t decode(input logic [31:0] ins, input logic [2:0] f3_mem);
        dec_t d;
        d.cls    = CLS_ILLEGAL;
        d.alu_op = ALU_ADD;
        case (ins[6:0])
            OPC_OP: begin
                if (ins[14:12] == F3_ADD_SUB && ins[31:25] == F7_ADD) begin
                    d.cls = CLS_ALU;
                end else if (ins[14:12] == F3_ADD_SUB && ins[31:25] == F7_SUB) begin
                    d.cls    = CLS_ALU;
                    d.alu_op = ALU_SUB;
                end
            end
            OPC_OP_IMM: if (ins[14:12] == F3_ADDI) d.cls = CLS_ADDI;
            OPC_LOAD:   if (ins[14:12] == f3_mem)  d.cls = CLS_LOAD;
            OPC_STORE:  if (ins[14:12] == f3_mem)  d.cls = CLS_STORE;
            OPC_BRANCH: begin
                if (ins[14:12] == F3_BEQ) begin
                    d.cls    = CLS_BRANCH;
                    d.alu_op = ALU_SUB;
                end
            end
            default: d.cls = CLS_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fsm_datapath_regfile.sv
// regfile: architectural register file for fsm_datapath.
// Two combinational read ports, one synchronous write port; x0 always
// reads zero and writes to it are dropped. All registers clear on rst.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   raddr1/rdata1         read port 1
//   raddr2/rdata2         read port 2
//   we, waddr, wdata      write port (takes effect on the rising edge)
module regfile
    import fsm_datapath_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(NREG)-1:0] raddr1,
    input  logic [$clog2(NREG)-1:0] raddr2,
    output logic [XLEN-1:0]         rdata1,
    output logic [XLEN-1:0]         rdata2,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [XLEN-1:0]         wdata
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values.
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/fsm_datapath.sv
// fsm_datapath: multicycle RV subset core (add, sub, addi, ld/lw, sd/sw, beq)
// stepping FETCH -> DECODE -> EXEC -> [MEM] -> [WB], with instruction and
// data memories held internally.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   imem_we/imem_addr/imem_wdata  instruction memory word write
//   PC                            address of the instruction in flight
//   New_PC                        next PC, valid while retire is high
//   ans                           ALU result of the latest executed instruction
//   I                             latched instruction word
//   retire                        one-cycle pulse in each instruction's last state
//   trap                          sticky illegal-instruction flag
// Build option: define ILLEGAL_TRAP_EN to park in TRAP on an illegal
// instruction; otherwise illegal words run as a 3-cycle NOP and trap stays 0.
module fsm_datapath
    import fsm_datapath_pkg::*;
#(
    parameter int          XLEN       = 64,
    parameter int          NREG       = 32,
    parameter int          IMEM_DEPTH = 64,
    parameter int          DMEM_DEPTH = 64,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_wdata,
    output logic [XLEN-1:0]               PC,
    output logic [XLEN-1:0]               New_PC,
    output logic [XLEN-1:0]               ans,
    output logic [31:0]                   I,
    output logic                          retire,
    output logic                          trap
);

    localparam int              IMEM_AW    = $clog2(IMEM_DEPTH);
    localparam int              DMEM_AW    = $clog2(DMEM_DEPTH);
    localparam int              RAW        = $clog2(NREG);
    localparam int              BYTE_SHIFT = (XLEN == 64) ? 3 : 2;
    localparam logic [2:0]      F3_MEM     = (XLEN == 64) ? F3_DWORD : F3_WORD;
    localparam logic [XLEN-1:0] PC_INIT    = RESET_PC[XLEN-1:0];

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];

    state_e          state;
    dec_t            dec;
    logic [XLEN-1:0] mdr;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] imm_i, imm_s, imm_b;
    logic [XLEN-1:0] alu_b, alu_res, wb_data;
    logic            branch_taken;
    logic            rf_we;
    logic [IMEM_AW-1:0] fetch_idx;
    logic [DMEM_AW-1:0] data_idx;

    assign dec   = decode(I, F3_MEM);
    assign imm_i = {{(XLEN-12){I[31]}}, I[31:20]};
    assign imm_s = {{(XLEN-12){I[31]}}, I[31:25], I[11:7]};
    assign imm_b = {{(XLEN-13){I[31]}}, I[31], I[7], I[30:25], I[11:8], 1'b0};

    always_comb begin
        // NOTE: default first so every path assigns alu_b; a missed branch would infer a latch.
        alu_b = rs2_val;
        case (dec.cls)
            CLS_ADDI, CLS_LOAD: alu_b = imm_i;
            CLS_STORE:          alu_b = imm_s;
            default:            alu_b = rs2_val;
        endcase
    end

    assign alu_res      = (dec.alu_op == ALU_SUB) ? rs1_val - alu_b : rs1_val + alu_b;
    assign branch_taken = (dec.cls == CLS_BRANCH) && (rs1_val == rs2_val);

    // Upper PC bits are ignored so fetch wraps; ans holds the byte address
    // during MEM, and its low bits are dropped to form a word index.
    assign fetch_idx = PC[IMEM_AW+1:2];
    assign data_idx  = ans[BYTE_SHIFT +: DMEM_AW];

    assign rf_we   = (state == S_WB);
    assign wb_data = (dec.cls == CLS_LOAD) ? mdr : ans;

    regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (I[15 +: RAW]),
        .raddr2 (I[20 +: RAW]),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (rf_we),
        .waddr  (I[7 +: RAW]),
        .wdata  (wb_data)
    );

    // NOTE: memories have no reset branch; clock-only processes keep contents across rst.
    always_ff @(posedge clk) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
    end

    // A reset mid-store forces state to FETCH asynchronously, so the write is abandoned.
    always_ff @(posedge clk) begin
        if (state == S_MEM && dec.cls == CLS_STORE) dmem[data_idx] <= rs2_val;
    end

    // retire is registered, so it is raised on the edge that enters an
    // instruction's final state; the edge leaving that state moves PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_FETCH;
            PC     <= PC_INIT;
            New_PC <= PC_INIT;
            ans    <= '0;
            I      <= '0;
            mdr    <= '0;
            retire <= 1'b0;
            trap   <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    I     <= imem[fetch_idx];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    New_PC <= branch_taken ? PC + imm_b : PC + XLEN'(4);
                    if (dec.cls == CLS_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
                        state <= S_TRAP;
                        trap  <= 1'b1;
`else
                        state  <= S_EXEC;
                        retire <= 1'b1;
`endif
                    end else begin
                        state  <= S_EXEC;
                        retire <= (dec.cls == CLS_BRANCH);
                    end
                end
                S_EXEC: begin
                    if (dec.cls != CLS_ILLEGAL) ans <= alu_res;
                    case (dec.cls)
                        CLS_ALU, CLS_ADDI: begin
                            state  <= S_WB;
                            retire <= 1'b1;
                        end
                        CLS_LOAD:  state <= S_MEM;
                        CLS_STORE: begin
                            state  <= S_MEM;
                            retire <= 1'b1;
                        end
                        default: begin
                            state <= S_FETCH;
                            PC    <= New_PC;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dec.cls == CLS_LOAD) begin
                        mdr    <= dmem[data_idx];
                        state  <= S_WB;
                        retire <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                        PC    <= New_PC;
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                    PC    <= New_PC;
                end
                S_TRAP:  state <= S_TRAP;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_datapath.sv
// Directed self-checking bench for fsm_datapath (64-bit and 32-bit builds).
// Data memory is seeded by running a short store program, then resetting
// (reset leaves memories intact) and loading the program under test.
module tb_fsm_datapath;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [63:0] pc, new_pc, ans;
    logic [31:0] ins;
    logic        retire, trap;

    logic        rst32, imem_we32;
    logic [5:0]  imem_addr32;
    logic [31:0] imem_wdata32;
    logic [31:0] pc32, new_pc32, ans32;
    logic [31:0] ins32;
    logic        retire32, trap32;

    int n_tests = 0;
    int n_fail  = 0;

    fsm_datapath u_dut (
        .clk        (clk),
        .rst        (rst),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .PC         (pc),
        .New_PC     (new_pc),
        .ans        (ans),
        .I          (ins),
        .retire     (retire),
        .trap       (trap)
    );

    fsm_datapath #(.XLEN(32)) u_dut32 (
        .clk        (clk),
        .rst        (rst32),
        .imem_we    (imem_we32),
        .imem_addr  (imem_addr32),
        .imem_wdata (imem_wdata32),
        .PC         (pc32),
        .New_PC     (new_pc32),
        .ans        (ans32),
        .I          (ins32),
        .retire     (retire32),
        .trap       (trap32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int idx, input logic [31:0] w);
        imem_addr  = 6'(idx);
        imem_wdata = w;
        imem_we    = 1'b1;
        step();
        imem_we    = 1'b0;
    endtask

    task automatic load32(input int idx, input logic [31:0] w);
        imem_addr32  = 6'(idx);
        imem_wdata32 = w;
        imem_we32    = 1'b1;
        step();
        imem_we32    = 1'b0;
    endtask

    // ld x2,0(x9); ld x1,8(x9); beq x2,x1,+12; sub x3,x2,x1; sd x3,16(x9);
    // addi x3,x2,-20; sd x3,16(x9)
    task automatic load_main();
        load(0, 32'h0004B103);
        load(1, 32'h0084B083);
        load(2, 32'h00110663);
        load(3, 32'h401101B3);
        load(4, 32'h0034B823);
        load(5, 32'hFEC10193);
        load(6, 32'h0034B823);
    endtask

    // addi x5,x0,m0; sd x5,0(x0); addi x5,x0,m1; sd x5,8(x0)  (16 cycles)
    task automatic seed_dmem(input logic [31:0] addi_m0, input logic [31:0] addi_m1);
        load(0, addi_m0);
        load(1, 32'h00503023);
        load(2, addi_m1);
        load(3, 32'h00503423);
        rst = 1'b0;
        steps(16);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] mask;
        rst = 1'b1; imem_we = 1'b0; imem_addr = '0; imem_wdata = '0;
        rst32 = 1'b1; imem_we32 = 1'b0; imem_addr32 = '0; imem_wdata32 = '0;
        @(negedge clk);

        // Reset state
        check("rst_pc", pc, 64'd0);
        check("rst_new_pc", new_pc, 64'd0);
        check("rst_ans", ans, 64'd0);
        check("rst_I", {32'd0, ins}, 64'd0);
        check("rst_retire", {63'd0, retire}, 64'd0);
        check("rst_trap", {63'd0, trap}, 64'd0);

        // Branch not taken: mem[0]=30, mem[1]=10
        seed_dmem(32'h01E00293, 32'h00A00293);
        load_main();
        rst  = 1'b0;
        mask = '0;
        for (int c = 1; c <= 21; c++) begin
            if (retire) mask[c] = 1'b1;
            if (c == 2) check("t1_I_first", {32'd0, ins}, 64'h0004B103);
            if (c == 13) begin
                check("t1_beq_pc", pc, 64'd8);
                check("t1_beq_new_pc", new_pc, 64'd12);
            end
            if (c == 17) check("t1_sub_ans", ans, 64'd20);
            step();
        end
        check("t1_retire_cycles", {32'd0, mask}, 64'h0000_0000_0022_2420);
        check("t1_mem2", u_dut.dmem[2], 64'd20);
        check("t1_pc_after_sd", pc, 64'd20);
        rst = 1'b1;

        // Branch taken: mem[0]=mem[1]=10
        seed_dmem(32'h00A00293, 32'h00A00293);
        load_main();
        rst = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            if (c == 13) begin
                check("t2_beq_retire", {63'd0, retire}, 64'd1);
                check("t2_beq_pc", pc, 64'd8);
                check("t2_beq_new_pc", new_pc, 64'd20);
            end
            if (c == 14) check("t2_pc_target", pc, 64'd20);
            if (c == 17) check("t2_addi_ans", ans, 64'hFFFF_FFFF_FFFF_FFF6);
            step();
        end
        check("t2_mem2", u_dut.dmem[2], 64'hFFFF_FFFF_FFFF_FFF6);
        rst = 1'b1;

        // x0 stays zero: addi x1,x0,7; addi x0,x0,5; add x1,x0,x0
        load(0, 32'h00700093);
        load(1, 32'h00500013);
        load(2, 32'h000000B3);
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 8) check("t3_addi_x0_ans", ans, 64'd5);
            if (c == 9) check("t3_x1_preset", u_dut.u_regfile.regs[1], 64'd7);
            if (c == 12) begin
                check("t3_add_ans", ans, 64'd0);
                check("t3_add_retire", {63'd0, retire}, 64'd1);
            end
            step();
        end
        check("t3_x1", u_dut.u_regfile.regs[1], 64'd0);
        check("t3_x0", u_dut.u_regfile.regs[0], 64'd0);
        rst = 1'b1;

        // Reset during MEM of sd: addi x5,x0,30; sd x5,0(x0); mem[0] holds 10
        load(0, 32'h01E00293);
        load(1, 32'h00503023);
        rst = 1'b0;
        steps(7);
        check("t4_sd_retire", {63'd0, retire}, 64'd1);
        check("t4_sd_pc", pc, 64'd4);
        rst = 1'b1;
        #1;
        check("t4_async_pc", pc, 64'd0);
        check("t4_async_retire", {63'd0, retire}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("t4_mem0_kept", u_dut.dmem[0], 64'd10);
        check("t4_x5_cleared", u_dut.u_regfile.regs[5], 64'd0);

        // Illegal instruction
        load(0, 32'hFFFFFFFF);
        rst = 1'b0;
        steps(2);
`ifdef ILLEGAL_TRAP_EN
        check("t5_trap_set", {63'd0, trap}, 64'd1);
        check("t5_no_retire", {63'd0, retire}, 64'd0);
        for (int c = 0; c < 10; c++) begin
            step();
            check("t5_pc_frozen", pc, 64'd0);
            check("t5_hold_retire", {63'd0, retire}, 64'd0);
        end
        check("t5_trap_sticky", {63'd0, trap}, 64'd1);
`else
        check("t5_nop_retire", {63'd0, retire}, 64'd1);
        check("t5_nop_new_pc", new_pc, 64'd4);
        check("t5_nop_pc", pc, 64'd0);
        check("t5_trap_zero", {63'd0, trap}, 64'd0);
        step();
        check("t5_pc_next", pc, 64'd4);
`endif
        rst = 1'b1;

        // XLEN=32: addi x1,x0,-1; sw x1,8(x0); addi x2,x0,5; sw x2,14(x0); lw x3,12(x0)
        load32(0, 32'hFFF00093);
        load32(1, 32'h00102423);
        load32(2, 32'h00500113);
        load32(3, 32'h00202723);
        load32(4, 32'h00C02183);
        rst32 = 1'b0;
        step();
        check("t6_I_first", {32'd0, ins32}, 64'h0000_0000_FFF0_0093);
        steps(19);
        check("t6_lw_retire", {63'd0, retire32}, 64'd1);
        check("t6_lw_ans", {32'd0, ans32}, 64'd12);
        check("t6_lw_pc", {32'd0, pc32}, 64'd16);
        check("t6_lw_new_pc", {32'd0, new_pc32}, 64'd20);
        check("t6_trap", {63'd0, trap32}, 64'd0);
        step();
        check("t6_x1", {32'd0, u_dut32.u_regfile.regs[1]}, 64'h0000_0000_FFFF_FFFF);
        check("t6_mem2", {32'd0, u_dut32.dmem[2]}, 64'h0000_0000_FFFF_FFFF);
        check("t6_mem3_misaligned", {32'd0, u_dut32.dmem[3]}, 64'd5);
        check("t6_x3_lw", {32'd0, u_dut32.u_regfile.regs[3]}, 64'd5);
        rst32 = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
